dma_engine_wrr_arb: RTL
=======================

DMA_ENGINE_WRR_ARB -- requirements
Module: dma_engine_wrr_arb

Interface
REQ-001 Parameter NUM_QUEUES, default 16: number of CNET queues; power of two, range 2..32.
REQ-002 Parameter BURST_W, default 4: width of the per-queue burst limit.
REQ-003 Localparam QW = clog2(NUM_QUEUES): queue index width.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cnet_reprog  in  1  CNET reprogramming; same effect as reset.
REQ-008 dma_pkt_avail  in  NUM_QUEUES  per-queue packet available.
REQ-009 queue_enable  in  NUM_QUEUES  per-queue read enable mask; 0 excludes the queue from arbitration.
REQ-010 burst_limit  in  BURST_W  consecutive reads per queue before rotating; 0 is treated as 1.
REQ-011 dma_rd_request  in  1  engine accepts the current grant.
REQ-012 ctrl_done  in  1  transfer complete pulse.
REQ-013 xfer_is_rd  in  1  current transfer is a read (CNET to host).
REQ-014 dma_wr_mac  in  QW  target queue for a write transfer.
REQ-015 dma_wr_mac_one_hot  out  NUM_QUEUES  one-hot decode of dma_wr_mac.
REQ-016 dma_rd_request_q  out  QW  granted read queue.
REQ-017 dma_rd_request_q_vld  out  1  dma_rd_request_q is valid and its queue has a packet.
REQ-018 arb_state  out  2  current FSM state, for debug.

Function
REQ-019 The FSM SHALL have states SEARCH, VALID and BUSY.
REQ-020 SEARCH: each cycle, examine scan_ptr; if dma_pkt_avail[scan_ptr] and queue_enable[scan_ptr], then next cycle dma_rd_request_q=scan_ptr, vld=1, state=VALID; else scan_ptr = scan_ptr+1 modulo NUM_QUEUES.
REQ-021 SEARCH SHALL scan indefinitely with wrap-around; a full pass with no hit keeps scanning with no error state.
REQ-022 Grant latency from entering SEARCH SHALL be k+1 cycles, where k is the modulo distance from pref_ptr to the first eligible queue; worst case is NUM_QUEUES cycles.
REQ-023 VALID: if dma_rd_request and xfer_is_rd, vld falls next cycle and state becomes BUSY.
REQ-024 VALID: if the granted queue loses avail or enable and there is no request, vld falls next cycle, scan_ptr=pref_ptr and state becomes SEARCH; a request in the same cycle takes precedence.
REQ-025 BUSY: on ctrl_done and xfer_is_rd, burst_cnt increments. If burst_cnt+1 >= max(burst_limit,1), then pref_ptr = granted+1 (wrapping) and burst_cnt = 0; else pref_ptr = granted. scan_ptr takes the new pref_ptr and state becomes SEARCH.
REQ-026 ctrl_done with xfer_is_rd=0 SHALL be ignored in every state.
REQ-027 dma_rd_request in SEARCH or BUSY SHALL be ignored.
REQ-028 In BUSY, if dma_rd_request and ctrl_done occur in the same cycle, ctrl_done SHALL win.
REQ-029 burst_cnt SHALL saturate and never wrap; a burst_limit change takes effect at the next ctrl_done.
REQ-030 The burst state (burst_cnt) SHALL be cleared whenever SEARCH grants a queue other than the previous grant.
REQ-031 dma_wr_mac_one_hot SHALL be combinational: bit i = (dma_wr_mac == i).

Reset
REQ-032 On reset or cnet_reprog, the block SHALL load: state=SEARCH, pref_ptr=0, scan_ptr=0, burst_cnt=0, dma_rd_request_q=NUM_QUEUES-1, vld=0.
REQ-033 reset or cnet_reprog SHALL override all other inputs, including in mid-BUSY; an in-flight grant is discarded.

Structure
REQ-034 Package dma_arb_pkg SHALL hold the state encoding (SEARCH=0, VALID=1, BUSY=2) and a clog2 function.
REQ-035 Sub-module dma_onehot_dec (parameter N) SHALL be used for both the dma_wr_mac decode and the scan_ptr eligibility decode.

Verification
REQ-036 N=16, reset, avail=0x0008, enable=all -> vld at cycle 4 after reset release, q=3.
REQ-037 burst_limit=2, avail=0x0003, four read request/done cycles -> grant sequence 0,0,1,1.
REQ-038 burst_limit=0, avail=0xFFFF -> grant sequence 0,1,2,...,15,0 (0 behaves as 1).
REQ-039 enable=0xFFFE, avail=0x0001 -> vld stays 0 for 40 cycles; then enable=0xFFFF -> vld=1, q=0 within 16 cycles.
REQ-040 VALID on q=5, avail[5] dropped -> vld 0 next cycle, state=SEARCH; separately, cnet_reprog in BUSY -> q=15, vld=0, pref=0; and ctrl_done with xfer_is_rd=0 -> no state change.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the weighted round-robin DMA read arbiter.
// The state encoding is also the debug value driven on arb_state.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VALID  = 2'd1,
        BUSY   = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dma_onehot_dec.sv
// Binary index to one-hot decoder: bit i of the output is set when idx == i.
module dma_onehot_dec
    import dma_arb_pkg::*;
#(
    parameter int N = 16,
    localparam int W = clog2(N)
) (
    input  logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = (idx == W'(i));
        end
    end

endmodule

// File: rtl/dma_engine_wrr_arb.sv
// Read-queue arbiter for the DMA engine: scans queues round-robin and lets a
// queue keep the grant for up to burst_limit consecutive reads before rotating.
module dma_engine_wrr_arb
    import dma_arb_pkg::*;
#(
    parameter int NUM_QUEUES = 16,
    parameter int BURST_W    = 4,
    localparam int QW        = clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cnet_reprog,
    input  logic [NUM_QUEUES-1:0] dma_pkt_avail,
    input  logic [NUM_QUEUES-1:0] queue_enable,
    input  logic [BURST_W-1:0]    burst_limit,
    input  logic                  dma_rd_request,
    input  logic                  ctrl_done,
    input  logic                  xfer_is_rd,
    input  logic [QW-1:0]         dma_wr_mac,
    output logic [NUM_QUEUES-1:0] dma_wr_mac_one_hot,
    output logic [QW-1:0]         dma_rd_request_q,
    output logic                  dma_rd_request_q_vld,
    output logic [1:0]            arb_state
);

    arb_state_e           state_q, state_d;
    logic [QW-1:0]        scan_q, scan_d;
    logic [QW-1:0]        pref_q, pref_d;
    logic [QW-1:0]        grant_q, grant_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic                 vld_q, vld_d;

    logic [NUM_QUEUES-1:0] scan_hot;
    logic                  scan_eligible;
    logic                  grant_ok;
    logic [BURST_W:0]      cnt_plus;
    logic [BURST_W:0]      limit_eff;
    logic                  burst_over;
    logic [BURST_W-1:0]    cnt_sat;
    logic [QW-1:0]         next_pref;

    dma_onehot_dec #(.N(NUM_QUEUES)) u_wr_mac_dec (
        .idx    (dma_wr_mac),
        .onehot (dma_wr_mac_one_hot)
    );

    dma_onehot_dec #(.N(NUM_QUEUES)) u_scan_dec (
        .idx    (scan_q),
        .onehot (scan_hot)
    );

    assign scan_eligible = |(scan_hot & dma_pkt_avail & queue_enable);
    assign grant_ok      = dma_pkt_avail[grant_q] & queue_enable[grant_q];

    // A zero limit behaves as one read per turn.
    assign limit_eff  = (burst_limit == '0) ? (BURST_W+1)'(1) : {1'b0, burst_limit};
    assign cnt_plus   = {1'b0, cnt_q} + (BURST_W+1)'(1);
    assign burst_over = (cnt_plus >= limit_eff);
    assign cnt_sat    = (&cnt_q) ? cnt_q : cnt_q + BURST_W'(1);
    assign next_pref  = burst_over ? grant_q + QW'(1) : grant_q;

    always_comb begin
        state_d = state_q;
        scan_d  = scan_q;
        pref_d  = pref_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        vld_d   = vld_q;
        case (state_q)
            SEARCH: begin
                if (scan_eligible) begin
                    grant_d = scan_q;
                    vld_d   = 1'b1;
                    state_d = VALID;
                    if (scan_q != grant_q) begin
                        cnt_d = '0;
                    end
                end else begin
                    scan_d = scan_q + QW'(1);
                end
            end
            VALID: begin
                // An accepted read wins over the queue going away in the same cycle.
                if (dma_rd_request && xfer_is_rd) begin
                    vld_d   = 1'b0;
                    state_d = BUSY;
                end else if (!grant_ok) begin
                    vld_d   = 1'b0;
                    scan_d  = pref_q;
                    state_d = SEARCH;
                end
            end
            BUSY: begin
                if (ctrl_done && xfer_is_rd) begin
                    pref_d  = next_pref;
                    scan_d  = next_pref;
                    cnt_d   = burst_over ? '0 : cnt_sat;
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || cnet_reprog) begin
            state_q <= SEARCH;
            scan_q  <= '0;
            pref_q  <= '0;
            grant_q <= QW'(NUM_QUEUES - 1);
            cnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            pref_q  <= pref_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
        end
    end

    assign dma_rd_request_q     = grant_q;
    assign dma_rd_request_q_vld = vld_q;
    assign arb_state            = state_q;

endmodule
